hist_eq_engine: RTL and testbench

//   Parametrised histogram-equalisation engine. Next generation of the histogram datapath.
//   - Builds a grey-level histogram of an image held in an external input RAM.
//   - Converts the histogram to a cumulative distribution and a remap LUT.
//   - Streams the equalised image to an external output RAM.
//   - Sits between the input pixel RAM (1-cycle read latency) and the output RAM in the image top level.

---
 rtl/hist_eq_engine.sv | 198 +++++++++++++++++++
 tb/tb_hist_eq_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_eq_engine.sv
// hist_eq_engine: histogram-equalisation engine.
// Builds a grey-level histogram from the input RAM, turns it into a CDF-based
// remap LUT held in the same storage, then streams the remapped image out.
// Optional feature macro: HIST_READOUT_EN adds an IDLE-time raw histogram readout port.
module hist_eq_engine #(
    parameter int W         = 64,
    parameter int H         = 64,
    parameter int PIX_BITS  = 8,
    parameter int TOTAL_BIT = $clog2(W*H)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [TOTAL_BIT-1:0] rd_addr,
    input  logic [PIX_BITS-1:0]  rd_data,
    output logic                 wr_en,
    output logic [TOTAL_BIT-1:0] wr_addr,
    output logic [PIX_BITS-1:0]  wr_data
`ifdef HIST_READOUT_EN
    ,
    input  logic [PIX_BITS-1:0]  hist_rd_addr,
    output logic [TOTAL_BIT:0]   hist_rd_data
`endif
);

    localparam int LEVELS = 2**PIX_BITS;
    localparam int TOTAL  = W*H;
    localparam int BIN_W  = TOTAL_BIT + 1;
    localparam int MEM_W  = (BIN_W > PIX_BITS) ? BIN_W : PIX_BITS;
    localparam int CNT_W  = ((TOTAL_BIT > PIX_BITS) ? TOTAL_BIT : PIX_BITS) + 2;
    localparam int PROD_W = TOTAL_BIT + 1 + PIX_BITS;

    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(LEVELS - 1);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(TOTAL + 2);
    localparam logic [CNT_W-1:0] CDF_LAST   = CNT_W'(LEVELS + 1);
    localparam logic [CNT_W-1:0] MAP_LAST   = CNT_W'(TOTAL + 1);
    localparam logic [CNT_W-1:0] ISSUE_END  = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] BIN_END    = CNT_W'(LEVELS);

    typedef enum logic [2:0] {IDLE, CLEAR, COUNT, CDF, MAP, DONE} state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt;
    logic                 issue;
    logic                 v1, v2;
    logic [PIX_BITS-1:0]  pix_d;
    logic [TOTAL_BIT-1:0] a1, a2;
    logic                 cdf_v;
    logic [PIX_BITS-1:0]  k_d;
    logic [BIN_W-1:0]     cdf, cdf_sum;
    logic [PROD_W-1:0]    lut_prod;
    logic [PIX_BITS-1:0]  lut_val;
    logic [MEM_W-1:0]     bin_inc;
    logic                 fwd;

    logic [MEM_W-1:0]     mem [LEVELS];
    logic [MEM_W-1:0]     mem_q;
    logic                 mem_we;
    logic [PIX_BITS-1:0]  mem_waddr, mem_raddr;
    logic [MEM_W-1:0]     mem_wdata;

    assign busy    = (state != IDLE) && (state != DONE);
    assign done    = (state == DONE);
    assign issue   = ((state == COUNT) || (state == MAP)) && (cnt < ISSUE_END);
    assign rd_addr = issue ? cnt[TOTAL_BIT-1:0] : '0;
    assign wr_en   = (state == MAP) && v2;
    assign wr_addr = wr_en ? a2 : '0;
    assign wr_data = wr_en ? mem_q[PIX_BITS-1:0] : '0;

    assign bin_inc  = MEM_W'(mem_q[BIN_W-1:0]) + MEM_W'(1);
    assign cdf_sum  = cdf + mem_q[BIN_W-1:0];
    assign lut_prod = PROD_W'(cdf_sum) * PROD_W'(LEVELS - 1);
    assign lut_val  = PIX_BITS'(lut_prod >> TOTAL_BIT);
    assign fwd      = (state == COUNT) && v1 && v2 && (pix_d == rd_data);

    // Next-state sequencing; each phase length is fixed by its step counter.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start)             state_n = CLEAR;
            CLEAR:   if (cnt == CLEAR_LAST) state_n = COUNT;
            COUNT:   if (cnt == COUNT_LAST) state_n = CDF;
            CDF:     if (cnt == CDF_LAST)   state_n = MAP;
            MAP:     if (cnt == MAP_LAST)   state_n = DONE;
            DONE:                           state_n = IDLE;
            default:                        state_n = IDLE;
        endcase
    end

    // Shared bin RAM port steering: clear, increment, or LUT write-back.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_raddr = rd_data;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt[PIX_BITS-1:0];
            end
            COUNT: begin
                mem_we    = v2;
                mem_waddr = pix_d;
                mem_wdata = bin_inc;
            end
            CDF: begin
                mem_raddr = cnt[PIX_BITS-1:0];
                mem_we    = cdf_v;
                mem_waddr = k_d;
                mem_wdata = MEM_W'(lut_val);
            end
            default: ;
        endcase
    end

    // State register and per-phase step counter, restarted on every phase change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if ((state_n != state) || (state == IDLE))
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Pixel and CDF pipeline stages plus the running cumulative sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            a1    <= '0;
            a2    <= '0;
            pix_d <= '0;
            cdf_v <= 1'b0;
            k_d   <= '0;
            cdf   <= '0;
        end else begin
            v1    <= issue;
            a1    <= cnt[TOTAL_BIT-1:0];
            v2    <= v1;
            a2    <= a1;
            pix_d <= rd_data;
            cdf_v <= (state == CDF) && (cnt < BIN_END);
            k_d   <= cnt[PIX_BITS-1:0];
            if (state != CDF)
                cdf <= '0;
            else if (cdf_v)
                cdf <= cdf_sum;
        end
    end

    // Bin/LUT storage write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Registered read, with the in-flight increment forwarded for repeated pixels.
    always_ff @(posedge clk) begin
        if (rst)
            mem_q <= '0;
        else if (fwd)
            mem_q <= bin_inc;
        else
            mem_q <= mem[mem_raddr];
    end

`ifdef HIST_READOUT_EN
    logic [BIN_W-1:0] copy_mem [LEVELS];
    logic             copy_ok;

    // Raw bin copy tracks clear and count writes only, so the LUT never overwrites it.
    always_ff @(posedge clk) begin
        if (mem_we && ((state == CLEAR) || (state == COUNT)))
            copy_mem[mem_waddr] <= mem_wdata[BIN_W-1:0];
    end

    // Readout register updates only in IDLE and reads zero until a frame has completed.
    always_ff @(posedge clk) begin
        if (rst) begin
            copy_ok      <= 1'b0;
            hist_rd_data <= '0;
        end else begin
            if (state == DONE)
                copy_ok <= 1'b1;
            if (state == IDLE)
                hist_rd_data <= copy_ok ? copy_mem[hist_rd_addr] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_hist_eq_engine.sv
// tb_hist_eq_engine: self-checking bench for hist_eq_engine on a 4x4, 8-bit image.
// Define HIST_READOUT_EN to also exercise the histogram readout port.
module tb_hist_eq_engine;

   localparam int W       = 4;
   localparam int H       = 4;
   localparam int PIX     = 8;
   localparam int TB      = 4;
   localparam int TOTAL   = W*H;
   localparam int LEVELS  = 256;
   localparam int LATENCY = 2*LEVELS + 2*TOTAL + 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          busy;
   logic          done;
   logic [TB-1:0] rdAddr;
   logic [PIX-1:0] rdData;
   logic          wrEn;
   logic [TB-1:0] wrAddr;
   logic [PIX-1:0] wrData;
`ifdef HIST_READOUT_EN
   logic [PIX-1:0] histRdAddr;
   logic [TB:0]    histRdData;
`endif

   logic [PIX-1:0] img    [TOTAL];
   logic [PIX-1:0] outMem [TOTAL];
   int             expOut [TOTAL];
   int             writeCount  = 0;
   int             orderErrors = 0;
   int             doneCount   = 0;
   int             tests       = 0;
   int             failures    = 0;

   hist_eq_engine #(.W(W), .H(H), .PIX_BITS(PIX)) dut (
      .clk     (clock),
      .rst     (reset),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .rd_addr (rdAddr),
      .rd_data (rdData),
      .wr_en   (wrEn),
      .wr_addr (wrAddr),
      .wr_data (wrData)
`ifdef HIST_READOUT_EN
      ,
      .hist_rd_addr (histRdAddr),
      .hist_rd_data (histRdData)
`endif
   );

   // Free-running clock.
   always #5 clock = ~clock;

   // Input RAM model with one cycle of read latency.
   always @(posedge clock) rdData <= img[rdAddr];

   // Output RAM model: records writes, checks address order, counts done pulses.
   always @(negedge clock) begin
      if (!reset) begin
         if (wrEn) begin
            outMem[wrAddr] = wrData;
            if (int'(wrAddr) != (writeCount % TOTAL)) orderErrors++;
            writeCount++;
         end
         if (done) doneCount++;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Reference model: histogram, cumulative sum, scaled LUT, remapped image.
   task automatic computeExpected();
      int hist [LEVELS];
      int lut  [LEVELS];
      int run;
      for (int k = 0; k < LEVELS; k++) hist[k] = 0;
      for (int a = 0; a < TOTAL; a++) hist[img[a]] += 1;
      run = 0;
      for (int k = 0; k < LEVELS; k++) begin
         run += hist[k];
         lut[k] = (run * (LEVELS - 1)) / TOTAL;
      end
      for (int a = 0; a < TOTAL; a++) expOut[a] = lut[img[a]];
   endtask

   // Launches a frame; cycle 1 is the cycle after the accepting edge.
   task automatic applyStimulus(input bit holdStart, output int doneCycle, output int busyLow);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      if (!holdStart) start = 1'b0;
      doneCycle = -1;
      busyLow   = 0;
      for (int c = 1; c <= 5000; c++) begin
         @(negedge clock);
         if (done) begin
            doneCycle = c;
            break;
         end
         if (!busy) busyLow++;
      end
   endtask

   task automatic runAndCheck(input string name);
      int baseW;
      int baseD;
      int doneCycle;
      int busyLow;
      baseW = writeCount;
      baseD = doneCount;
      computeExpected();
      applyStimulus(1'b0, doneCycle, busyLow);
      #1;
      checkOutput({name, "_latency"}, doneCycle, LATENCY);
      checkOutput({name, "_busy_gap"}, busyLow, 0);
      checkOutput({name, "_busy_at_done"}, {31'd0, busy}, 0);
      checkOutput({name, "_writes"}, writeCount - baseW, TOTAL);
      checkOutput({name, "_dones"}, doneCount - baseD, 1);
      for (int a = 0; a < TOTAL; a++)
         checkOutput($sformatf("%s_pix%0d", name, a), {24'd0, outMem[a]}, expOut[a]);
      @(negedge clock);
      checkOutput({name, "_done_pulse"}, {31'd0, done}, 0);
      checkOutput({name, "_idle_busy"}, {31'd0, busy}, 0);
   endtask

   initial begin
      int doneCycle;
      int busyLow;
      int baseW;
      int baseD;
      reset = 1'b1;
      start = 1'b0;
      for (int a = 0; a < TOTAL; a++) img[a] = '0;
`ifdef HIST_READOUT_EN
      histRdAddr = 8'd5;
`endif
      repeat (3) @(negedge clock);
      checkOutput("rst_busy",   {31'd0, busy}, 0);
      checkOutput("rst_done",   {31'd0, done}, 0);
      checkOutput("rst_wr_en",  {31'd0, wrEn}, 0);
      checkOutput("rst_rd_addr", {28'd0, rdAddr}, 0);
      checkOutput("rst_wr_addr", {28'd0, wrAddr}, 0);
      checkOutput("rst_wr_data", {24'd0, wrData}, 0);
      reset = 1'b0;
      repeat (2) @(negedge clock);
`ifdef HIST_READOUT_EN
      checkOutput("readout_after_reset", {27'd0, histRdData}, 0);
`endif

      // Constant image.
      for (int a = 0; a < TOTAL; a++) img[a] = 8'd100;
      runAndCheck("flat");

      // Ramp image.
      for (int a = 0; a < TOTAL; a++) img[a] = PIX'(a);
      runAndCheck("ramp");

      // Alternating runs of equal pixels exercise forwarding.
      for (int a = 0; a < TOTAL; a++) img[a] = (((a / 4) % 2) == 0) ? 8'd5 : 8'd9;
      runAndCheck("runs");
`ifdef HIST_READOUT_EN
      histRdAddr = 8'd5;
      repeat (2) @(negedge clock);
      checkOutput("readout_bin5", {27'd0, histRdData}, 8);
      histRdAddr = 8'd9;
      repeat (2) @(negedge clock);
      checkOutput("readout_bin9", {27'd0, histRdData}, 8);
      histRdAddr = 8'd0;
      repeat (2) @(negedge clock);
      checkOutput("readout_bin0", {27'd0, histRdData}, 0);
`endif

      // Abort in COUNT, then a clean rerun.
      for (int a = 0; a < TOTAL; a++) img[a] = PIX'($urandom_range(0, 255));
      baseW = writeCount;
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (LEVELS + 10) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("abort_busy", {31'd0, busy}, 0);
      checkOutput("abort_wr_en", {31'd0, wrEn}, 0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("abort_no_writes", writeCount - baseW, 0);
      runAndCheck("rerun");

      // start held high across a frame and beyond.
      computeExpected();
      baseW = writeCount;
      baseD = doneCount;
      applyStimulus(1'b1, doneCycle, busyLow);
      checkOutput("hold_latency", doneCycle, LATENCY);
      @(negedge clock);
      checkOutput("hold_idle_gap", {31'd0, busy}, 0);
      @(negedge clock);
      checkOutput("hold_restart", {31'd0, busy}, 1);
      start = 1'b0;
      doneCycle = -1;
      for (int c = 2; c <= 5000; c++) begin
         @(negedge clock);
         if (done) begin
            doneCycle = c;
            break;
         end
      end
      #1;
      checkOutput("hold_second_latency", doneCycle, LATENCY);
      checkOutput("hold_dones", doneCount - baseD, 2);
      checkOutput("hold_writes", writeCount - baseW, 2*TOTAL);
      for (int a = 0; a < TOTAL; a++)
         checkOutput($sformatf("hold_pix%0d", a), {24'd0, outMem[a]}, expOut[a]);
      @(negedge clock);

      // Random images, one with a narrow range to force many repeats.
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < TOTAL; a++)
            img[a] = (r == 0) ? PIX'($urandom_range(0, 3)) : PIX'($urandom_range(0, 255));
         runAndCheck($sformatf("rand%0d", r));
      end

      checkOutput("write_order", orderErrors, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
